multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle RV32I control unit; successor to the single-cycle main decoder. Sequences each
//  instruction through FETCH/DECODE/EXECUTE/MEM/WB states over a shared memory port with a
//  req/ready handshake. Adds a wait-state watchdog, an illegal-opcode trap and a retired-instruction
//  counter. Sits between the instruction register (opcode/funct3 in) and the datapath muxes/enables.
// PARAMETERS
//  TIMEOUT   16  max cycles mem_req may wait for mem_ready before trapping; 0 disables the watchdog
//  RET_W     32  width of retired-instruction counter
// PORTS
//  clk          in   1      system clock, all state updates on rising edge
//  rst          in   1      synchronous, active-high reset
//  opcode       in   7      instr[6:0] from instruction register
//  funct3       in   3      instr[14:12]; bit0 selects BEQ(0)/BNE(1)
//  zero         in   1      ALU zero flag
//  mem_ready    in   1      memory completes current access this cycle
//  mem_req      out  1      memory access request (held until mem_ready)
//  MemWrite     out  1      access is a store
//  AdrSrc       out  1      0=PC, 1=ALUOut as memory address
//  IRWrite      out  1      load instruction register
//  PCWrite      out  1      load PC from Result
//  RegWrite     out  1      register file write enable
//  ALUSrcA      out  2      00=PC, 01=OldPC, 10=RD1
//  ALUSrcB      out  2      00=RD2, 01=ImmExt, 10=const 4
//  ImmSrc       out  2      00=I, 01=S, 10=B, 11=J
//  ALU_Op       out  2      00=add, 01=sub, 10=decode funct
//  ResultSrc    out  2      00=ALUOut, 01=ReadData, 10=ALUResult
//  trap         out  1      sticky fault flag
//  trap_cause   out  2      00=none, 01=illegal opcode, 10=memory timeout
//  retired      out  RET_W  count of completed instructions, wraps at 2^RET_W
// BEHAVIOUR
//  - Moore outputs decoded from registered state; PCWrite in BRANCH and IRWrite/PCWrite in FETCH
//    also depend on current-cycle inputs. All outputs not listed for a state are 0.
//  - rst high: next state FETCH, wait counter 0, retired 0, trap/trap_cause 0. While rst is high
//    all outputs are forced to 0.
//  - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU_Op=00, ResultSrc=10.
//    On mem_ready: IRWrite=1, PCWrite=1, go to DECODE; else stay in FETCH.
//  - DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, ALU_Op=00. Next state by opcode:
//    0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH,
//    1101111 -> JAL, any other opcode -> TRAP with cause 01.
//  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALU_Op=00, ImmSrc=00 (load) or 01 (store).
//    Next state MEMRD (load) or MEMWR (store).
//  - MEMRD: mem_req=1, AdrSrc=1. Go to MEMWB on mem_ready.
//  - MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
//  - MEMWR: mem_req=1, AdrSrc=1, MemWrite=1. Go to FETCH on mem_ready.
//  - EXECR: ALUSrcA=10, ALUSrcB=00, ALU_Op=10. Go to ALUWB.
//  - EXECI: same as EXECR but ALUSrcB=01, ImmSrc=00. Go to ALUWB.
//  - ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
//  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALU_Op=01, ResultSrc=00, PCWrite=zero^funct3[0]. Go to FETCH.
//  - JAL: ALUSrcA=01, ALUSrcB=10, ALU_Op=00, ResultSrc=00, PCWrite=1. Go to ALUWB.
//  - TRAP: all control outputs 0, trap=1, cause held. Exited only by rst.
//  - Latency: R/I 4 cycles, lw 5, sw 4, branch 3, jal 4, each plus memory wait cycles.
//  - Watchdog:
//    counter increments each cycle mem_req=1 && !mem_ready, and clears on mem_ready or
//    state change. When counter reaches TIMEOUT-1 with mem_ready still 0, next state is
//    TRAP with cause 10. mem_ready in that same cycle wins: the access completes, no trap.
//  - retired increments by 1 on entry to FETCH from MEMWB, MEMWR (ready), ALUWB or BRANCH.
//    It is not incremented on reset exit or on trap.
//  - Reset mid-access: mem_req drops the same cycle rst is sampled; a pending access is abandoned.
// STRUCTURE
//  - riscv_ctrl_pkg holds:
//    - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL)
//    - 4-bit state encodings
//    - ALU_Op, ImmSrc, ResultSrc, ALUSrcA/B and trap_cause codes
//  - One sub-module, mem_wait_timer (TIMEOUT): counter, clear/enable, expire output;
//    tied off when TIMEOUT=0.
//  - Top holds the state register, next-state logic, output decode and the retired counter.
// TESTING
//  - R-type add (opcode 0110011), mem_ready=1 always:
//    4 cycles; RegWrite=1 only in cycle 4; retired 0->1.
//  - lw with mem_ready delayed 3 cycles in MEMRD:
//    mem_req=1, AdrSrc=1 held 4 cycles; MEMWB has ResultSrc=01, RegWrite=1.
//  - beq, zero=1, funct3=000: PCWrite=1 in BRANCH.
//    zero=1, funct3=001 (bne): PCWrite=0. Both go back to FETCH.
//  - opcode 0110111 (unsupported):
//    DECODE -> TRAP; trap=1, trap_cause=01, all enables 0 for 10 cycles.
//  - TIMEOUT=16, mem_ready held 0 in FETCH: trap_cause=10 after 16 request cycles.
//    mem_ready=1 on cycle 16: no trap, IRWrite=1.
//  - rst asserted in MEMWR with mem_req=1: next cycle all outputs 0; after release FETCH, retired=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Shared encodings for the multi-cycle RV32I control unit:
//               opcodes, FSM state encoding, datapath mux select codes,
//               trap causes and the DECODE dispatch helper.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

    // Supported major opcodes (instr[6:0])
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Controller states, 4-bit encoding
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    // ALU operation class
    localparam logic [1:0] c_alu_add   = 2'b00;
    localparam logic [1:0] c_alu_sub   = 2'b01;
    localparam logic [1:0] c_alu_funct = 2'b10;

    // Immediate format select
    localparam logic [1:0] c_imm_i = 2'b00;
    localparam logic [1:0] c_imm_s = 2'b01;
    localparam logic [1:0] c_imm_b = 2'b10;
    localparam logic [1:0] c_imm_j = 2'b11;

    // Result mux select
    localparam logic [1:0] c_res_aluout    = 2'b00;
    localparam logic [1:0] c_res_readdata  = 2'b01;
    localparam logic [1:0] c_res_aluresult = 2'b10;

    // ALU operand A select
    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_rd1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] c_srcb_rd2  = 2'b00;
    localparam logic [1:0] c_srcb_imm  = 2'b01;
    localparam logic [1:0] c_srcb_four = 2'b10;

    // Trap cause codes
    localparam logic [1:0] c_cause_none    = 2'b00;
    localparam logic [1:0] c_cause_illegal = 2'b01;
    localparam logic [1:0] c_cause_timeout = 2'b10;

    // State that follows DECODE for a given opcode; unknown opcodes trap
    function automatic state_t decode_next(input logic [6:0] op);
        state_t v_next;
        v_next = S_TRAP;
        case (op)
            OP_LW, OP_SW: v_next = S_MEMADR;
            OP_R:         v_next = S_EXECR;
            OP_I:         v_next = S_EXECI;
            OP_B:         v_next = S_BRANCH;
            OP_JAL:       v_next = S_JAL;
            default:      v_next = S_TRAP;
        endcase
        return v_next;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts consecutive cycles a memory request waits without
//               mem_ready. expire pulses on the TIMEOUT-th waiting cycle.
//               TIMEOUT = 0 removes the counter and holds expire low.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,      // request outstanding and not ready this cycle
    input  logic clr,     // no wait in progress: restart the count
    output logic expire
);

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

            logic [CW-1:0] r_count;

            // Wait-cycle counter; clear has priority over counting
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    r_count <= '0;
                end else if (en) begin
                    r_count <= r_count + CW'(1);
                end
            end

            // r_count holds the number of earlier waiting cycles, so this
            // cycle is the TIMEOUT-th when it equals TIMEOUT-1
            assign expire = en && (r_count == CW'(TIMEOUT - 1));
        end else begin : g_no_timer
            logic w_unused;
            assign w_unused = ^{clk, rst, en, clr};
            assign expire   = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_fsm
// Description : Multi-cycle RV32I control unit. Sequences FETCH / DECODE /
//               EXECUTE / MEM / WB over a shared req/ready memory port,
//               traps on illegal opcodes and memory timeouts, and counts
//               retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int RET_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       ALU_Op,
    output logic [1:0]       ResultSrc,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [RET_W-1:0] retired
);

    state_t           r_state;
    logic [1:0]       r_cause;
    logic [RET_W-1:0] r_retired;

    logic w_wait;
    logic w_expire;
    logic w_unused_funct3;

    // Only the BEQ/BNE selector bit of funct3 matters to the controller
    assign w_unused_funct3 = ^funct3[2:1];

    // A wait cycle is a live request that memory has not completed
    assign w_wait = mem_req && !mem_ready;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (w_wait),
        .clr    (!w_wait),
        .expire (w_expire)
    );

    // State register, sticky trap cause and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_cause   <= c_cause_none;
            r_retired <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_expire) begin
                        r_state <= S_TRAP;
                        r_cause <= c_cause_timeout;
                    end
                end
                S_DECODE: begin
                    r_state <= decode_next(opcode);
                    if (decode_next(opcode) == S_TRAP) begin
                        r_cause <= c_cause_illegal;
                    end
                end
                S_MEMADR: begin
                    r_state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    if (mem_ready) begin
                        r_state <= S_MEMWB;
                    end else if (w_expire) begin
                        r_state <= S_TRAP;
                        r_cause <= c_cause_timeout;
                    end
                end
                S_MEMWB: begin
                    r_state   <= S_FETCH;
                    r_retired <= r_retired + RET_W'(1);
                end
                S_MEMWR: begin
                    if (mem_ready) begin
                        r_state   <= S_FETCH;
                        r_retired <= r_retired + RET_W'(1);
                    end else if (w_expire) begin
                        r_state <= S_TRAP;
                        r_cause <= c_cause_timeout;
                    end
                end
                S_EXECR, S_EXECI: begin
                    r_state <= S_ALUWB;
                end
                S_ALUWB, S_BRANCH: begin
                    r_state   <= S_FETCH;
                    r_retired <= r_retired + RET_W'(1);
                end
                S_JAL: begin
                    r_state <= S_ALUWB;
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // Control outputs decoded from state; everything is held low during reset
    always_comb begin
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = c_srca_pc;
        ALUSrcB   = c_srcb_rd2;
        ImmSrc    = c_imm_i;
        ALU_Op    = c_alu_add;
        ResultSrc = c_res_aluout;
        trap      = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    AdrSrc    = 1'b0;
                    ALUSrcA   = c_srca_pc;
                    ALUSrcB   = c_srcb_four;
                    ALU_Op    = c_alu_add;
                    ResultSrc = c_res_aluresult;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcA = c_srca_oldpc;
                    ALUSrcB = c_srcb_imm;
                    ImmSrc  = c_imm_b;
                    ALU_Op  = c_alu_add;
                end
                S_MEMADR: begin
                    ALUSrcA = c_srca_rd1;
                    ALUSrcB = c_srcb_imm;
                    ALU_Op  = c_alu_add;
                    ImmSrc  = (opcode == OP_SW) ? c_imm_s : c_imm_i;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = c_res_readdata;
                    RegWrite  = 1'b1;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = c_srca_rd1;
                    ALUSrcB = c_srcb_rd2;
                    ALU_Op  = c_alu_funct;
                end
                S_EXECI: begin
                    ALUSrcA = c_srca_rd1;
                    ALUSrcB = c_srcb_imm;
                    ImmSrc  = c_imm_i;
                    ALU_Op  = c_alu_funct;
                end
                S_ALUWB: begin
                    ResultSrc = c_res_aluout;
                    RegWrite  = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA   = c_srca_rd1;
                    ALUSrcB   = c_srcb_rd2;
                    ALU_Op    = c_alu_sub;
                    ResultSrc = c_res_aluout;
                    PCWrite   = zero ^ funct3[0];
                end
                S_JAL: begin
                    ALUSrcA   = c_srca_oldpc;
                    ALUSrcB   = c_srcb_four;
                    ALU_Op    = c_alu_add;
                    ResultSrc = c_res_aluout;
                    PCWrite   = 1'b1;
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    trap = 1'b0;
                end
            endcase
        end
    end

    // Cause and count are architecturally visible but masked while in reset
    assign trap_cause = rst ? c_cause_none : r_cause;
    assign retired    = rst ? '0 : r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl_fsm
// Description : Self-checking bench for multicycle_ctrl_fsm. An instruction-
//               level model (per-instruction step plans) predicts every
//               control output each cycle; directed literals pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

    localparam int TO = 16;

    // Model step identifiers
    localparam int P_FETCH = 0,  P_DEC = 1, P_ADR = 2, P_RD  = 3;
    localparam int P_MWB   = 4,  P_WR  = 5, P_EXR = 6, P_EXI = 7;
    localparam int P_WB    = 8,  P_BR  = 9, P_JAL = 10, P_TRAP = 11;

    localparam logic [6:0] L_LW  = 7'b0000011, L_SW = 7'b0100011;
    localparam logic [6:0] L_R   = 7'b0110011, L_I  = 7'b0010011;
    localparam logic [6:0] L_B   = 7'b1100011, L_J  = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = L_R;
    logic [2:0]  funct3 = 3'b000;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, trap;
    logic [1:0]  ALUSrcA, ALUSrcB, ImmSrc, ALU_Op, ResultSrc, trap_cause;
    logic [31:0] retired;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.TIMEOUT(TO), .RET_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALU_Op(ALU_Op), .ResultSrc(ResultSrc),
        .trap(trap), .trap_cause(trap_cause), .retired(retired)
    );

    logic [18:0] act_vec;
    assign act_vec = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                      ALUSrcA, ALUSrcB, ImmSrc, ALU_Op, ResultSrc, trap, trap_cause};

    int          n_pass = 0;
    int          n_total = 0;
    logic        chk_en = 1'b0;
    logic [18:0] exp_vec = '0;
    logic [31:0] exp_ret = '0;

    // Model state: current step, remaining steps of the instruction, etc.
    int          m_ph = P_FETCH;
    int          plan[$];
    int          m_wait = 0;
    logic [31:0] m_ret = '0;
    logic [1:0]  m_cause = 2'b00;
    logic [6:0]  next_op = L_R;
    logic [2:0]  next_f3 = 3'b000;
    bit          rand_mode = 1'b0;

    // Observations captured at the sampling edge for directed checks
    int ob_req, ob_adr, ob_ir, ob_pc, ob_rw, ob_res, ob_trap, ob_cause, ob_ret;

    // Per-cycle comparison of all outputs against the model prediction
    always @(negedge clk) begin
        if (chk_en) begin
            n_total++;
            if (act_vec === exp_vec && retired === exp_ret) n_pass++;
            else $display("FAIL cycle_outputs t=%0t step=%0d actual=%b ret=%0d required=%b ret=%0d",
                          $time, m_ph, act_vec, retired, exp_vec, exp_ret);
        end
    end

    task automatic check_lit(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    // Output table per instruction step, straight from the control definition
    function automatic logic [18:0] exp_out(input int ph, input logic rdy, input logic z,
                                            input logic [2:0] f3, input logic [6:0] op,
                                            input logic [1:0] cause);
        logic req, mw, adr, irw, pcw, rw, tr;
        logic [1:0] sa, sb, imm, aop, res, cs;
        req = 0; mw = 0; adr = 0; irw = 0; pcw = 0; rw = 0; tr = 0;
        sa = 0; sb = 0; imm = 0; aop = 0; res = 0; cs = 0;
        case (ph)
            P_FETCH: begin req = 1; sb = 2; res = 2; irw = rdy; pcw = rdy; end
            P_DEC:   begin sa = 1; sb = 1; imm = 2; end
            P_ADR:   begin sa = 2; sb = 1; imm = (op == L_SW) ? 2'd1 : 2'd0; end
            P_RD:    begin req = 1; adr = 1; end
            P_MWB:   begin res = 1; rw = 1; end
            P_WR:    begin req = 1; adr = 1; mw = 1; end
            P_EXR:   begin sa = 2; aop = 2; end
            P_EXI:   begin sa = 2; sb = 1; aop = 2; end
            P_WB:    begin rw = 1; end
            P_BR:    begin sa = 2; aop = 1; pcw = z ^ f3[0]; end
            P_JAL:   begin sa = 1; sb = 2; pcw = 1; end
            P_TRAP:  begin tr = 1; cs = cause; end
            default: begin tr = 0; end
        endcase
        return {req, mw, adr, irw, pcw, rw, sa, sb, imm, aop, res, tr, cs};
    endfunction

    // Steps an instruction takes after its fetch completes
    task automatic build_plan(input logic [6:0] op);
        plan.delete();
        plan.push_back(P_DEC);
        case (op)
            L_R:     begin plan.push_back(P_EXR); plan.push_back(P_WB); end
            L_I:     begin plan.push_back(P_EXI); plan.push_back(P_WB); end
            L_LW:    begin plan.push_back(P_ADR); plan.push_back(P_RD); plan.push_back(P_MWB); end
            L_SW:    begin plan.push_back(P_ADR); plan.push_back(P_WR); end
            L_B:     plan.push_back(P_BR);
            L_J:     begin plan.push_back(P_JAL); plan.push_back(P_WB); end
            default: plan.push_back(P_TRAP);
        endcase
    endtask

    task automatic pick_next();
        int r;
        logic [6:0] bad [5];
        bad[0] = 7'b0110111; bad[1] = 7'b0010111; bad[2] = 7'b1100111;
        bad[3] = 7'b1110011; bad[4] = 7'b0000000;
        r = $urandom_range(0, 39);
        if      (r < 6)  next_op = L_R;
        else if (r < 12) next_op = L_I;
        else if (r < 18) next_op = L_LW;
        else if (r < 24) next_op = L_SW;
        else if (r < 31) next_op = L_B;
        else if (r < 38) next_op = L_J;
        else             next_op = bad[$urandom_range(0, 4)];
        next_f3 = 3'($urandom_range(0, 7));
    endtask

    task automatic model_reset();
        m_ph = P_FETCH; m_wait = 0; m_ret = '0; m_cause = 2'b00; plan.delete();
    endtask

    task automatic finish_instr();
        m_ret = m_ret + 32'd1;
        m_ph  = P_FETCH;
    endtask

    task automatic mem_stall();
        m_wait++;
        if (TO != 0 && m_wait >= TO) begin m_ph = P_TRAP; m_cause = 2'b10; end
    endtask

    // Advance the model by one clock using the inputs of the finished cycle
    task automatic advance(input logic rdy);
        if (m_ph == P_TRAP) begin
            m_ph = P_TRAP;
        end else if (m_ph == P_FETCH || m_ph == P_RD || m_ph == P_WR) begin
            if (!rdy) mem_stall();
            else begin
                m_wait = 0;
                if (m_ph == P_FETCH) begin
                    opcode = next_op; funct3 = next_f3;
                    build_plan(next_op);
                    m_ph = plan.pop_front();
                    if (rand_mode) pick_next();
                end else if (plan.size() == 0) finish_instr();
                else m_ph = plan.pop_front();
            end
        end else if (plan.size() == 0) begin
            finish_instr();
        end else begin
            m_ph = plan.pop_front();
            if (m_ph == P_TRAP) m_cause = 2'b01;
        end
    endtask

    // One clock: drive inputs, predict, let the compare process sample, advance
    task automatic tick(input logic rdy, input logic z);
        mem_ready = rdy; zero = z;
        if (rst) begin exp_vec = '0; exp_ret = '0; end
        else begin
            exp_vec = exp_out(m_ph, rdy, z, funct3, opcode, m_cause);
            exp_ret = m_ret;
        end
        chk_en = 1'b1;
        @(negedge clk);
        ob_req = int'(mem_req); ob_adr = int'(AdrSrc); ob_ir = int'(IRWrite);
        ob_pc = int'(PCWrite); ob_rw = int'(RegWrite); ob_res = int'(ResultSrc);
        ob_trap = int'(trap); ob_cause = int'(trap_cause); ob_ret = int'(retired);
        @(posedge clk); #1;
        if (rst) model_reset(); else advance(rdy);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        int cnt, at, stall_left, trap_cycles;
        logic rdy_c;
        @(posedge clk); #1;

        // R-type add with memory always ready
        next_op = L_R; next_f3 = 3'b000;
        do_reset(2);
        cnt = 0; at = 0;
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1, 1'b0);
            if (i == 1) check_lit("reset_retired", ob_ret, 0);
            if (ob_rw == 1) begin cnt++; at = i; end
        end
        check_lit("r_regwrite_count", cnt, 1);
        check_lit("r_regwrite_cycle", at, 4);

        // lw with three wait cycles in MEMRD
        next_op = L_LW;
        tick(1'b1, 1'b0);
        check_lit("r_retired", ob_ret, 1);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0);
        cnt = 0;
        repeat (3) begin tick(1'b0, 1'b0); if (ob_req == 1 && ob_adr == 1) cnt++; end
        tick(1'b1, 1'b0); if (ob_req == 1 && ob_adr == 1) cnt++;
        check_lit("lw_req_cycles", cnt, 4);
        tick(1'b1, 1'b0);
        check_lit("lw_wb_resultsrc", ob_res, 1);
        check_lit("lw_wb_regwrite", ob_rw, 1);

        // beq taken, then bne with zero=1 not taken
        next_op = L_B; next_f3 = 3'b000;
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b1);
        check_lit("beq_pcwrite", ob_pc, 1);
        next_op = L_B; next_f3 = 3'b001;
        tick(1'b1, 1'b0);
        check_lit("branch_back_to_fetch", ob_req, 1);
        tick(1'b1, 1'b0); tick(1'b1, 1'b1);
        check_lit("bne_pcwrite", ob_pc, 0);

        // Watchdog fires after TO request cycles in FETCH
        repeat (TO) tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check_lit("timeout_trap", ob_trap, 1);
        check_lit("timeout_cause", ob_cause, 2);
        do_reset(1);

        // mem_ready on the last allowed cycle wins
        next_op = L_R;
        repeat (TO - 1) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check_lit("timeout_edge_irwrite", ob_ir, 1);
        tick(1'b1, 1'b0);
        check_lit("timeout_edge_no_trap", ob_trap, 0);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0);

        // Unsupported opcode traps and stays trapped
        next_op = 7'b0110111;
        tick(1'b1, 1'b0); tick(1'b1, 1'b0);
        cnt = 0;
        repeat (10) begin tick(1'b1, 1'b1); if (ob_trap == 1 && ob_cause == 1) cnt++; end
        check_lit("illegal_trap_cycles", cnt, 10);
        do_reset(1);

        // Reset while a store is waiting in MEMWR
        next_op = L_SW;
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check_lit("memwr_req", ob_req, 1);
        rst = 1'b1;
        tick(1'b0, 1'b0);
        check_lit("rst_drops_req", ob_req, 0);
        tick(1'b0, 1'b0);
        rst = 1'b0;
        tick(1'b0, 1'b0);
        check_lit("post_rst_retired", ob_ret, 0);
        check_lit("post_rst_fetch", ob_req, 1);

        // Randomized instruction stream with random wait states
        rand_mode = 1'b1;
        pick_next();
        stall_left = 0; trap_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            if (m_ph == P_TRAP) begin
                trap_cycles++;
                if (trap_cycles > 5) begin do_reset(1); trap_cycles = 0; end
            end
            if (stall_left == 0 && $urandom_range(0, 149) == 0)
                stall_left = $urandom_range(10, 20);
            if (stall_left > 0) begin rdy_c = 1'b0; stall_left--; end
            else rdy_c = ($urandom_range(0, 3) != 0);
            tick(rdy_c, 1'($urandom_range(0, 1)));
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
